// File: rtl/match_controller.sv
// rtl/match_controller.sv - game-flow FSM: countdown, pause, elimination tracking, best-of-N scoring
// Moore outputs are decoded from the registered state, so every response lags its cause by one cycle.
module match_controller #(
  parameter int NUM_PLAYERS       = 2,
  parameter int ROUND_SECONDS     = 60,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int ROUNDS_TO_WIN     = 2,
  localparam int PID_W            = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enterPressed,
  input  logic                   pausePressed,
  input  logic                   one_sec,
  input  logic [NUM_PLAYERS-1:0] playerLose,
  output logic                   hideMap,
  output logic                   runEn,
  output logic                   randomPick,
  output logic                   pickMap,
  output logic                   paused,
  output logic                   showEnd,
  output logic                   roundEnd,
  output logic                   winnerValid,
  output logic [PID_W-1:0]       winnerId,
  output logic                   drawFlag,
  output logic [3:0]             roundIdx,
  output logic [3:0]             counter_tens,
  output logic [3:0]             counter_ones
);

  localparam int SEC_W = $clog2(100);
  localparam logic [SEC_W-1:0] CD_LOAD  = SEC_W'(COUNTDOWN_SECONDS);
  localparam logic [SEC_W-1:0] RUN_LOAD = SEC_W'(ROUND_SECONDS);
  localparam logic [3:0]       WIN_CNT  = 4'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE, PICK, COUNTDOWN, RUN, PAUSE, CHANGE, ROUND_END, MATCH_END
  } state_t;

  state_t state, state_next;

  logic [SEC_W-1:0]       sec;
  logic [NUM_PLAYERS-1:0] alive;
  logic [NUM_PLAYERS-1:0] alive_next;
  logic [3:0]             score [NUM_PLAYERS];
  logic [3:0]             round_idx;
  logic                   winner_valid;
  logic                   draw;
  logic [PID_W-1:0]       winner_id;

  logic [3:0]             alive_cnt;
  logic [PID_W-1:0]       win_idx;
  logic                   load_cd, load_run, dec_sec;
  logic                   new_round, clear_winner, end_round, update_alive, clear_match;
  logic                   match_won;
  logic [SEC_W-1:0]       shown;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Survivors after this cycle's losses; win_idx is only meaningful when exactly one remains.
  always_comb begin
    alive_next = alive & ~playerLose;
    alive_cnt  = '0;
    win_idx    = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (alive_next[i]) begin
        alive_cnt = alive_cnt + 4'd1;
        win_idx   = PID_W'(i);
      end
    end
  end

  assign match_won = winner_valid && (score[winner_id] == WIN_CNT);

  always_comb begin
    state_next   = state;
    load_cd      = 1'b0;
    load_run     = 1'b0;
    dec_sec      = 1'b0;
    new_round    = 1'b0;
    clear_winner = 1'b0;
    end_round    = 1'b0;
    update_alive = 1'b0;
    clear_match  = 1'b0;
    hideMap      = 1'b0;
    runEn        = 1'b0;
    randomPick   = 1'b0;
    pickMap      = 1'b0;
    paused       = 1'b0;
    showEnd      = 1'b0;
    roundEnd     = 1'b0;
    case (state)
      IDLE: begin
        hideMap = 1'b1;
        if (enterPressed) begin
          state_next   = PICK;
          new_round    = 1'b1;
          clear_winner = 1'b1;
        end
      end
      PICK: begin
        hideMap    = 1'b1;
        randomPick = 1'b1;
        load_cd    = 1'b1;
        state_next = COUNTDOWN;
      end
      COUNTDOWN: begin
        if (one_sec) begin
          if (sec == 7'd1) begin
            load_run   = 1'b1;
            state_next = RUN;
          end else begin
            dec_sec = 1'b1;
          end
        end
      end
      RUN: begin
        runEn        = 1'b1;
        update_alive = 1'b1;
        if (alive_cnt <= 4'd1) begin
          end_round  = 1'b1;
          state_next = ROUND_END;
        end else if (one_sec) begin
          if (sec == 7'd1) state_next = CHANGE;
          else             dec_sec    = 1'b1;
        end else if (pausePressed) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        paused = 1'b1;
        if (pausePressed) state_next = RUN;
      end
      CHANGE: begin
        hideMap    = 1'b1;
        pickMap    = 1'b1;
        load_run   = 1'b1;
        state_next = RUN;
      end
      ROUND_END: begin
        roundEnd = 1'b1;
        hideMap  = 1'b1;
        if (match_won) begin
          state_next = MATCH_END;
        end else if (enterPressed) begin
          state_next = PICK;
          new_round  = 1'b1;
        end
      end
      MATCH_END: begin
        showEnd = 1'b1;
        if (enterPressed) begin
          state_next  = IDLE;
          clear_match = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec          <= '0;
      alive        <= '1;
      round_idx    <= '0;
      winner_valid <= 1'b0;
      draw         <= 1'b0;
      winner_id    <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
    end else begin
      if (load_cd)       sec <= CD_LOAD;
      else if (load_run) sec <= RUN_LOAD;
      else if (dec_sec)  sec <= sec - 7'd1;

      if (update_alive) alive <= alive_next;

      if (new_round) begin
        alive <= '1;
        draw  <= 1'b0;
        if (round_idx != 4'd15) round_idx <= round_idx + 4'd1;
      end
      if (clear_winner) winner_valid <= 1'b0;

      if (end_round) begin
        if (alive_cnt == 4'd1) begin
          winner_id    <= win_idx;
          winner_valid <= 1'b1;
          draw         <= 1'b0;
          if (score[win_idx] != WIN_CNT) score[win_idx] <= score[win_idx] + 4'd1;
        end else begin
          draw         <= 1'b1;
          winner_valid <= 1'b0;
        end
      end

      if (clear_match) begin
        round_idx <= '0;
        for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
      end
    end
  end

  assign winnerValid = winner_valid || (state == MATCH_END);
  assign winnerId    = winner_id;
  assign drawFlag    = draw;
  assign roundIdx    = round_idx;

  always_comb begin
    shown = '0;
    if (state == COUNTDOWN || state == RUN || state == PAUSE || state == CHANGE) shown = sec;
    counter_tens = 4'(shown / 7'd10);
    counter_ones = 4'(shown % 7'd10);
  end

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - directed bench for match_controller with an expected-value queue
module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enterPressed, pausePressed, one_sec;
  logic [1:0] playerLose;
  logic       hideMap, runEn, randomPick, pickMap, paused, showEnd, roundEnd;
  logic       winnerValid, drawFlag;
  logic [0:0] winnerId;
  logic [3:0] roundIdx, counter_tens, counter_ones;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  match_controller #(
    .NUM_PLAYERS(2), .ROUND_SECONDS(60), .COUNTDOWN_SECONDS(3), .ROUNDS_TO_WIN(2)
  ) dut (
    .clk(clk), .reset(reset), .enterPressed(enterPressed), .pausePressed(pausePressed),
    .one_sec(one_sec), .playerLose(playerLose), .hideMap(hideMap), .runEn(runEn),
    .randomPick(randomPick), .pickMap(pickMap), .paused(paused), .showEnd(showEnd),
    .roundEnd(roundEnd), .winnerValid(winnerValid), .winnerId(winnerId), .drawFlag(drawFlag),
    .roundIdx(roundIdx), .counter_tens(counter_tens), .counter_ones(counter_ones)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input int obs);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=queued_value", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_enter();
    enterPressed = 1'b1; step(); enterPressed = 1'b0;
  endtask

  task automatic pulse_pause();
    pausePressed = 1'b1; step(); pausePressed = 1'b0;
  endtask

  task automatic tick();
    one_sec = 1'b1; step(); one_sec = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic lose(input logic [1:0] m);
    playerLose = m; step(); playerLose = 2'b00;
  endtask

  task automatic disp(input string tag, input int secs);
    push({tag, "_tens"}, secs / 10); chk(int'(counter_tens));
    push({tag, "_ones"}, secs % 10); chk(int'(counter_ones));
  endtask

  // From ROUND_END/IDLE: enter, PICK cycle, 3-second countdown into RUN.
  task automatic start_round(input int exp_round);
    pulse_enter();
    push("pick_random", 1); chk(int'(randomPick));
    push("pick_round", exp_round); chk(int'(roundIdx));
    step();
    ticks(3);
    push("run_en", 1); chk(int'(runEn));
  endtask

  initial begin
    reset = 1'b1; enterPressed = 1'b0; pausePressed = 1'b0; one_sec = 1'b0; playerLose = 2'b00;
    step(); step();
    reset = 1'b0;
    step();

    push("rst_hide", 1); chk(int'(hideMap));
    push("rst_run", 0); chk(int'(runEn));
    push("rst_round", 0); chk(int'(roundIdx));
    push("rst_wv", 0); chk(int'(winnerValid));
    disp("rst", 0);

    // Countdown display 3,2,1 then RUN at 60
    pulse_enter();
    push("t1_rpick", 1); chk(int'(randomPick));
    push("t1_round", 1); chk(int'(roundIdx));
    step();
    push("t1_rpick_once", 0); chk(int'(randomPick));
    push("t1_cd_run", 0); chk(int'(runEn));
    disp("t1_cd3", 3);
    pulse_pause();
    push("t1_pause_ignored", 0); chk(int'(paused));
    tick(); disp("t1_cd2", 2);
    tick(); disp("t1_cd1", 1);
    tick();
    push("t1_run", 1); chk(int'(runEn));
    disp("t1_run60", 60);

    // Pause freezes seconds and ignores losses
    ticks(18);
    disp("t4_sec42", 42);
    pulse_pause();
    push("t4_paused", 1); chk(int'(paused));
    push("t4_run_off", 0); chk(int'(runEn));
    ticks(5);
    lose(2'b01);
    disp("t4_frozen", 42);
    push("t4_no_end", 0); chk(int'(roundEnd));
    pulse_pause();
    push("t4_resume", 1); chk(int'(runEn));
    disp("t4_resume42", 42);

    // Time-out map change, then a full 60-second window
    ticks(42);
    push("t3_pickmap", 1); chk(int'(pickMap));
    push("t3_hide", 1); chk(int'(hideMap));
    step();
    push("t3_pickmap_once", 0); chk(int'(pickMap));
    push("t3_run", 1); chk(int'(runEn));
    disp("t3_reload", 60);
    ticks(59);
    disp("t3_sec1", 1);
    push("t3_still_run", 1); chk(int'(runEn));
    tick();
    push("t3_pickmap2", 1); chk(int'(pickMap));
    step();
    disp("t3_reload2", 60);

    // Enter ignored during RUN
    pulse_enter();
    push("enter_ignored_run", 1); chk(int'(runEn));
    push("enter_ignored_round", 1); chk(int'(roundIdx));

    // Player 0 destroyed: player 1 wins round 1
    lose(2'b01);
    push("t2_round_end", 1); chk(int'(roundEnd));
    push("t2_winner", 1); chk(int'(winnerId));
    push("t2_wv", 1); chk(int'(winnerValid));
    push("t2_draw", 0); chk(int'(drawFlag));
    disp("t2_disp", 0);
    step();
    push("t2_hold", 1); chk(int'(roundEnd));

    // Simultaneous loss: draw, no score
    start_round(2);
    lose(2'b11);
    push("t5_round_end", 1); chk(int'(roundEnd));
    push("t5_draw", 1); chk(int'(drawFlag));
    push("t5_wv", 0); chk(int'(winnerValid));

    // Player 0 takes two rounds; player 1 remains at one win
    start_round(3);
    push("t6_draw_clear", 0); chk(int'(drawFlag));
    lose(2'b10);
    push("t6_winner_a", 0); chk(int'(winnerId));
    push("t6_wv_a", 1); chk(int'(winnerValid));
    step();
    push("t6_not_match", 0); chk(int'(showEnd));
    push("t6_still_end", 1); chk(int'(roundEnd));
    start_round(4);
    lose(2'b10);
    push("t6_winner_b", 0); chk(int'(winnerId));
    step();
    push("t6_show_end", 1); chk(int'(showEnd));
    push("t6_end_wv", 1); chk(int'(winnerValid));
    push("t6_end_re", 0); chk(int'(roundEnd));
    pulse_enter();
    push("t6_idle_hide", 1); chk(int'(hideMap));
    push("t6_idle_round", 0); chk(int'(roundIdx));
    push("t6_idle_show", 0); chk(int'(showEnd));

    // Scores were cleared: a single win for player 1 must not end the match
    start_round(1);
    push("new_match_wv", 0); chk(int'(winnerValid));
    lose(2'b01);
    push("new_match_winner", 1); chk(int'(winnerId));
    step();
    push("new_match_no_end", 0); chk(int'(showEnd));

    // Mid-RUN reset
    start_round(2);
    reset = 1'b1; step(); reset = 1'b0;
    push("mid_rst_hide", 1); chk(int'(hideMap));
    push("mid_rst_run", 0); chk(int'(runEn));
    push("mid_rst_round", 0); chk(int'(roundIdx));
    disp("mid_rst", 0);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
